scan_deframer: RTL and testbench

//   Receiving end of the raster scan: accepts a pixel stream in scan order,

---
 rtl/scan_deframer_pkg.sv | 18 +
 rtl/scan_deframer_if.sv | 30 +++
 rtl/scan_pos_counter.sv | 38 +++
 rtl/scan_deframer.sv | 128 ++++++++++++
 tb/tb_scan_deframer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_deframer_pkg.sv
// Shared geometry, widths and state encoding for the scan deframer.
// Latency: none, declarations only.
// Backpressure: none. Defining BANK_SWAP_EN adds one framebuffer bank bit to AW_DEF.
package scan_pkg;
   localparam int HTOTAL_DEF = 128;
   localparam int VTOTAL_DEF = 128;
   localparam int DW_DEF     = 16;
   localparam int XW         = $clog2(HTOTAL_DEF);
   localparam int YW         = $clog2(VTOTAL_DEF);
`ifdef BANK_SWAP_EN
   localparam int BANK_W     = 1;
`else
   localparam int BANK_W     = 0;
`endif
   localparam int AW_DEF     = YW + XW + BANK_W;

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
endpackage

// File: rtl/scan_deframer_if.sv
// Pixel-stream input and framebuffer write port bundled for the scan deframer.
// Latency: none, wiring only.
// Backpressure: pix_ready and fb_ready form the valid/ready pairs.
interface scan_deframer_if
   import scan_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
);
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sof;
   logic [DW-1:0] pix_data;
   logic          fb_ready;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_wdata;

   // The environment drives the source beat and the framebuffer ready.
   modport master (
      output pix_valid, pix_sof, pix_data, fb_ready,
      input  pix_ready, fb_we, fb_addr, fb_wdata
   );

   // The deframer drives its input ready and the framebuffer write.
   modport slave (
      input  pix_valid, pix_sof, pix_data, fb_ready,
      output pix_ready, fb_we, fb_addr, fb_wdata
   );
endinterface

// File: rtl/scan_pos_counter.sv
// Raster (x,y) position counter with a one-cycle advance and a load of (1,0).
// Latency: the new position is visible the cycle after adv_i or load1_i.
// Backpressure: none. load1_i wins over adv_i, and both wrap naturally at full width.
module scan_pos_counter #(
   parameter int XW = 7,
   parameter int YW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv_i,
   input  logic          load1_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          x_last_o,
   output logic          y_last_o
);
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   assign x_o      = x_q;
   assign y_o      = y_q;
   assign x_last_o = &x_q;
   assign y_last_o = &y_q;

   // Move the position: restart just past the origin, or step in scan order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (load1_i) begin
         x_q <= XW'(1);
         y_q <= '0;
      end else if (adv_i) begin
         x_q <= x_q + 1'b1;
         if (x_last_o) y_q <= y_q + 1'b1;
      end
   end
endmodule

// File: rtl/scan_deframer.sv
// Tracks raster position on a pixel stream and writes each beat to the framebuffer.
// Latency: a beat accepted in cycle N drives fb_we/fb_addr/fb_wdata from cycle N+1.
// Backpressure: one-entry write register, pix_ready = fb_ready | ~pending. BANK_SWAP_EN adds the bank MSB.
module scan_deframer
   import scan_pkg::*;
#(
   parameter int HTOTAL = HTOTAL_DEF,
   parameter int VTOTAL = VTOTAL_DEF,
   parameter int DW     = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   scan_deframer_if.slave  bus,
   output logic            locked,
   output logic            frame_done,
   output logic            sync_err
);
   localparam int XBITS = $clog2(HTOTAL);
   localparam int YBITS = $clog2(VTOTAL);
   localparam int PW    = YBITS + XBITS;
   localparam int AW    = PW + BANK_W;

   logic [XBITS-1:0] x;
   logic [YBITS-1:0] y;
   logic             x_last, y_last;
   logic             accept, at_origin, issue;
   logic             do_write, do_load1, do_adv, lose_sync, bad_sof;
   logic [PW-1:0]    pos_d;
   logic [AW-1:0]    addr_d;
   state_t           state_q;
   logic             sync_err_q;
   logic             we_q, last_q;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;

   scan_pos_counter #(.XW(XBITS), .YW(YBITS)) u_pos (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (do_adv),
      .load1_i  (do_load1),
      .x_o      (x),
      .y_o      (y),
      .x_last_o (x_last),
      .y_last_o (y_last)
   );

   assign bus.pix_ready = bus.fb_ready | ~we_q;
   assign accept        = bus.pix_valid & bus.pix_ready;
   assign at_origin     = (x == '0) && (y == '0);
   assign issue         = we_q & bus.fb_ready;
   assign frame_done    = issue & last_q;
   assign sync_err      = sync_err_q;
   assign locked        = (state_q == LOCK);
   assign bus.fb_we     = we_q;
   assign bus.fb_addr   = addr_q;
   assign bus.fb_wdata  = wdata_q;

   // A start-of-frame beat always lands at (0,0); any other beat lands where the counter says.
   assign pos_d = bus.pix_sof ? '0 : {y, x};

`ifdef BANK_SWAP_EN
   logic bank_q, bank_d;
   // A beat accepted in the same cycle the last pixel issues already belongs to the next bank.
   assign bank_d = bank_q ^ frame_done;
   assign addr_d = {bank_d, pos_d};

   // Flip the bank once per completed frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bank_q <= 1'b0;
      else      bank_q <= bank_d;
   end
`else
   assign addr_d = pos_d;
`endif

   // Classify the accepted beat: write, restart the counters, advance, or drop.
   always_comb begin
      do_write  = 1'b0;
      do_load1  = 1'b0;
      do_adv    = 1'b0;
      lose_sync = 1'b0;
      bad_sof   = 1'b0;
      if (accept) begin
         if (bus.pix_sof) begin
            do_write = 1'b1;
            do_load1 = 1'b1;
            bad_sof  = (state_q == LOCK) && !at_origin;
         end else if (state_q == LOCK) begin
            if (at_origin) begin
               lose_sync = 1'b1;
            end else begin
               do_write = 1'b1;
               do_adv   = 1'b1;
            end
         end
      end
   end

   // Lock state machine with a registered sync-error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= HUNT;
         sync_err_q <= 1'b0;
      end else begin
         sync_err_q <= bad_sof | lose_sync;
         if (lose_sync)     state_q <= HUNT;
         else if (do_load1) state_q <= LOCK;
      end
   end

   // One-entry write register, held until the framebuffer takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (do_write) begin
         we_q    <= 1'b1;
         last_q  <= !bus.pix_sof && x_last && y_last;
         addr_q  <= addr_d;
         wdata_q <= bus.pix_data;
      end else if (issue) begin
         we_q    <= 1'b0;
         last_q  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_scan_deframer.sv
// Directed bench for scan_deframer: full frame, hunt, resync, stall and reset cases.
// Latency: writes are recorded on the falling edge in which they issue.
// Backpressure: fb_ready is driven low for a stall. With BANK_SWAP_EN defined, the two-frame bank case runs too.
module tb_scan_deframer;
   import scan_pkg::*;

   localparam int PW = XW + YW;
   localparam int NPIX = HTOTAL_DEF * VTOTAL_DEF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic locked, frame_done, sync_err;

   scan_deframer_if bus ();

   scan_deframer dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .locked     (locked),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW_DEF-1:0] wr_addr[$];
   logic [DW_DEF-1:0] wr_data[$];
   int                fd_cnt = 0;
   int                se_cnt = 0;
   int                cyc    = 0;
   logic [AW_DEF-1:0] fd_addr = '0;

   // Record every write the framebuffer takes, plus the status pulses.
   always @(negedge clk) begin
      cyc++;
      if (bus.fb_we && bus.fb_ready) begin
         wr_addr.push_back(bus.fb_addr);
         wr_data.push_back(bus.fb_wdata);
      end
      if (frame_done) begin
         fd_cnt++;
         fd_addr = bus.fb_addr;
      end
      if (sync_err) se_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW_DEF-1:0] pix_of(input int i);
      return DW_DEF'(i) ^ 16'hA5A5;
   endfunction

   // Offer one beat and hold it until accepted, with a bounded wait.
   task automatic send(input logic sof, input logic [DW_DEF-1:0] d);
      int   waits;
      logic acc;
      waits = 0;
      acc   = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_sof   = sof;
      bus.pix_data  = d;
      while (!acc && waits < 100) begin
         @(negedge clk);
         acc = bus.pix_ready;
         waits++;
         @(posedge clk);
         #1;
      end
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
   endtask

   int b, s0, e0, c0, errs;

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_data  = '0;
      bus.fb_ready  = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_fb_we", 32'(bus.fb_we), 32'd0);
      check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      idle(1);
      rst = 1'b1;
      idle(1);

      // Full frame, sof first, fb always ready
      b  = wr_addr.size();
      e0 = fd_cnt;
      s0 = se_cnt;
      c0 = cyc;
      for (int i = 0; i < NPIX; i++) send(i == 0, pix_of(i));
      check("t1_throughput", 32'(cyc - c0), 32'(NPIX));
      idle(3);
      check("t1_count", 32'(wr_addr.size() - b), 32'(NPIX));
      errs = 0;
      for (int i = 0; i < NPIX && (b + i) < wr_addr.size(); i++) begin
         logic [AW_DEF-1:0] a;
         a = wr_addr[b + i];
         if (a[PW-1:0] !== PW'(i) || wr_data[b + i] !== pix_of(i)) errs++;
      end
      check("t1_order", 32'(errs), 32'd0);
      check("t1_frame_done_cnt", 32'(fd_cnt - e0), 32'd1);
      check("t1_frame_done_addr", 32'(fd_addr[PW-1:0]), 32'(NPIX - 1));
      check("t1_locked", 32'(locked), 32'd1);
      check("t1_no_sync_err", 32'(se_cnt - s0), 32'd0);

      // Back at (0,0) in LOCK: a beat without sof loses lock and is dropped
      b  = wr_addr.size();
      s0 = se_cnt;
      send(1'b0, 16'h0BAD);
      idle(3);
      check("lose_sync_err", 32'(se_cnt - s0), 32'd1);
      check("lose_locked", 32'(locked), 32'd0);
      check("lose_dropped", 32'(wr_addr.size() - b), 32'd0);

      // Hunt: ten beats without sof are dropped, the sof beat lands at 0
      do_reset();
      b  = wr_addr.size();
      s0 = se_cnt;
      for (int i = 0; i < 10; i++) send(1'b0, 16'h1000 + 16'(i));
      idle(2);
      check("t2_hunt_drop", 32'(wr_addr.size() - b), 32'd0);
      send(1'b1, 16'hBEEF);
      for (int i = 1; i < 10; i++) send(1'b0, pix_of(i));
      idle(3);
      check("t2_count", 32'(wr_addr.size() - b), 32'd10);
      check("t2_first_addr", 32'(wr_addr[b][PW-1:0]), 32'd0);
      check("t2_first_data", 32'(wr_data[b]), 32'hBEEF);
      check("t2_last_addr", 32'(wr_addr[b + 9][PW-1:0]), 32'd9);
      check("t2_no_sync_err", 32'(se_cnt - s0), 32'd0);

      // sof injected at (5,2): restart at 0, next beat at 1
      for (int a = 10; a < 2 * HTOTAL_DEF + 5; a++) send(1'b0, pix_of(a));
      idle(3);
      b  = wr_addr.size();
      s0 = se_cnt;
      send(1'b1, 16'hC0DE);
      send(1'b0, 16'h1234);
      idle(3);
      check("t3_sync_err", 32'(se_cnt - s0), 32'd1);
      check("t3_count", 32'(wr_addr.size() - b), 32'd2);
      check("t3_addr0", 32'(wr_addr[b][PW-1:0]), 32'd0);
      check("t3_data0", 32'(wr_data[b]), 32'hC0DE);
      check("t3_addr1", 32'(wr_addr[b + 1][PW-1:0]), 32'd1);
      check("t3_data1", 32'(wr_data[b + 1]), 32'h1234);
      check("t3_locked", 32'(locked), 32'd1);

      // fb_ready low for three cycles while a write is pending
      b = wr_addr.size();
      send(1'b0, 16'h4444);
      bus.fb_ready  = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t4_pix_ready_low", 32'(bus.pix_ready), 32'd0);
         check("t4_we_held", 32'(bus.fb_we), 32'd1);
         check("t4_addr_held", 32'(bus.fb_addr[PW-1:0]), 32'd2);
         check("t4_wdata_held", 32'(bus.fb_wdata), 32'h4444);
      end
      @(posedge clk);
      #1;
      bus.fb_ready = 1'b1;
      send(1'b0, 16'h5555);
      send(1'b0, 16'h6666);
      idle(3);
      check("t4_count", 32'(wr_addr.size() - b), 32'd3);
      check("t4_a0", 32'({wr_addr[b][PW-1:0], wr_data[b]}), 32'h0002_4444);
      check("t4_a1", 32'({wr_addr[b + 1][PW-1:0], wr_data[b + 1]}), 32'h0003_5555);
      check("t4_a2", 32'({wr_addr[b + 2][PW-1:0], wr_data[b + 2]}), 32'h0004_6666);

      // Reset while the (64,64) write is pending, then resync
      for (int a = 5; a <= 64 * HTOTAL_DEF + 64; a++) send(1'b0, pix_of(a));
      b  = wr_addr.size();
      s0 = se_cnt;
      rst = 1'b0;
      @(negedge clk);
      check("t5_fb_we", 32'(bus.fb_we), 32'd0);
      check("t5_fb_addr", 32'(bus.fb_addr), 32'd0);
      check("t5_locked", 32'(locked), 32'd0);
      check("t5_frame_done", 32'(frame_done), 32'd0);
      check("t5_sync_err", 32'(sync_err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);
      send(1'b0, 16'h0001);
      send(1'b0, 16'h0002);
      send(1'b1, 16'h7777);
      send(1'b0, 16'h7778);
      send(1'b0, 16'h7779);
      idle(3);
      check("t5_count", 32'(wr_addr.size() - b), 32'd3);
      check("t5_first", 32'({wr_addr[b][PW-1:0], wr_data[b]}), 32'h0000_7777);
      check("t5_third", 32'({wr_addr[b + 2][PW-1:0], wr_data[b + 2]}), 32'h0002_7779);
      check("t5_locked", 32'(locked), 32'd1);
      check("t5_no_sync_err", 32'(se_cnt - s0), 32'd0);

`ifdef BANK_SWAP_EN
      // Two frames: bank MSB is 0 for the first, 1 for the second
      do_reset();
      b  = wr_addr.size();
      e0 = fd_cnt;
      for (int i = 0; i < 2 * NPIX; i++) send((i % NPIX) == 0, pix_of(i));
      idle(3);
      check("t6_count", 32'(wr_addr.size() - b), 32'(2 * NPIX));
      check("t6_f1_first_bank", 32'(wr_addr[b][AW_DEF-1]), 32'd0);
      check("t6_f1_last_bank", 32'(wr_addr[b + NPIX - 1][AW_DEF-1]), 32'd0);
      check("t6_f2_first_bank", 32'(wr_addr[b + NPIX][AW_DEF-1]), 32'd1);
      check("t6_f2_first_pos", 32'(wr_addr[b + NPIX][PW-1:0]), 32'd0);
      check("t6_f2_last_bank", 32'(wr_addr[b + 2 * NPIX - 1][AW_DEF-1]), 32'd1);
      check("t6_frame_done_cnt", 32'(fd_cnt - e0), 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
